// File: rtl/outbus_write_buffer.sv
// outbus_write_buffer: queues CPU output-port writes and replays them as
// single-cycle OUTBUS_WE strobes, in acceptance order, with optional idle spacing.
// Latency: a push into an empty buffer at edge N gives OUTBUS_WE high after N+1.
// Backpressure: cpu_wr_ready = (count < DEPTH) from registered count; a request
// presented while not ready is ignored and must be held by the CPU.
//
// Ports:
//   clk, reset_n                 single clock, async active-low reset
//   cpu_wr_addr/data/valid/ready CPU write request channel (valid/ready)
//   OUTBUS_ADDR/DATA/WE          registered bus outputs; ADDR/DATA hold between pulses
//   buf_count, buf_idle          registered occupancy and "empty and FSM idle"
//   stat_writes, stat_peak       only when OUTBUS_BUF_STATS_EN is defined:
//                                saturating pulse count and peak occupancy
module outbus_write_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [7:0]              cpu_wr_addr,
  input  logic [DATA_WIDTH-1:0]   cpu_wr_data,
  input  logic                    cpu_wr_valid,
  output logic                    cpu_wr_ready,
  output logic [7:0]              OUTBUS_ADDR,
  output logic [DATA_WIDTH-1:0]   OUTBUS_DATA,
  output logic                    OUTBUS_WE,
  output logic [$clog2(DEPTH):0]  buf_count,
  output logic                    buf_idle
`ifdef OUTBUS_BUF_STATS_EN
  ,
  output logic [15:0]             stat_writes,
  output logic [$clog2(DEPTH):0]  stat_peak
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  // Gap counter is loaded with GAP_CYCLES-1: the ISSUE->GAP edge plus the final
  // GAP->IDLE edge together account for the one extra cycle.
  localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic [7:0]            mem_addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_data_q [DEPTH];

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [1:0]            state_q, state_d;
  logic [3:0]            gap_q, gap_d;
  logic [7:0]            addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  we_q, we_d;
  logic                  idle_q, idle_d;
  logic                  push, pop;

  assign cpu_wr_ready = (count_q < DEPTH_C);
  assign push         = cpu_wr_valid && cpu_wr_ready;
  // Pops only from IDLE, which is what leaves at least one low cycle between strobes.
  assign pop          = (state_q == ST_IDLE) && (count_q != '0);

  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    addr_d   = addr_q;
    data_d   = data_q;
    we_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pop) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (GAP_CYCLES > 0) begin
          state_d = ST_GAP;
          gap_d   = GAP_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_q == 4'd0) state_d = ST_IDLE;
        else               gap_d   = gap_q - 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      count_d  = count_d + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      count_d  = count_d - 1'b1;
      addr_d   = mem_addr_q[rd_ptr_q];
      data_d   = mem_data_q[rd_ptr_q];
      we_d     = 1'b1;
    end

    idle_d = (count_d == '0) && (state_d == ST_IDLE);
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr_q[wr_ptr_q] <= cpu_wr_addr;
      mem_data_q[wr_ptr_q] <= cpu_wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= ST_IDLE;
      gap_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      we_q     <= 1'b0;
      idle_q   <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      gap_q    <= gap_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      we_q     <= we_d;
      idle_q   <= idle_d;
    end
  end

  assign OUTBUS_ADDR = addr_q;
  assign OUTBUS_DATA = data_q;
  assign OUTBUS_WE   = we_q;
  assign buf_count   = count_q;
  assign buf_idle    = idle_q;

`ifdef OUTBUS_BUF_STATS_EN
  logic [15:0]   writes_q, writes_d;
  logic [CW-1:0] peak_q, peak_d;

  always_comb begin
    writes_d = writes_q;
    if (pop && (writes_q != 16'hFFFF)) writes_d = writes_q + 16'd1;
    // Track the value buf_count takes on this same edge.
    peak_d = (count_d > peak_q) ? count_d : peak_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      writes_q <= '0;
      peak_q   <= '0;
    end else begin
      writes_q <= writes_d;
      peak_q   <= peak_d;
    end
  end

  assign stat_writes = writes_q;
  assign stat_peak   = peak_q;
`endif

endmodule

// File: tb/tb_outbus_write_buffer.sv
module tb_outbus_write_buffer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       sel = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] data = 8'h00;

  logic       a_valid, a_ready, a_we, a_idle;
  logic [7:0] a_addr, a_data;
  logic [2:0] a_count;
  logic       b_valid, b_ready, b_we, b_idle;
  logic [7:0] b_addr, b_data;
  logic [2:0] b_count;
`ifdef OUTBUS_BUF_STATS_EN
  logic [15:0] a_sw, b_sw;
  logic [2:0]  a_sp, b_sp;
`endif

  assign a_valid = valid & ~sel;
  assign b_valid = valid & sel;

  outbus_write_buffer #(.DATA_WIDTH(8), .DEPTH(4), .GAP_CYCLES(0)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .cpu_wr_addr(addr), .cpu_wr_data(data), .cpu_wr_valid(a_valid), .cpu_wr_ready(a_ready),
    .OUTBUS_ADDR(a_addr), .OUTBUS_DATA(a_data), .OUTBUS_WE(a_we),
    .buf_count(a_count), .buf_idle(a_idle)
`ifdef OUTBUS_BUF_STATS_EN
    , .stat_writes(a_sw), .stat_peak(a_sp)
`endif
  );

  outbus_write_buffer #(.DATA_WIDTH(8), .DEPTH(4), .GAP_CYCLES(3)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .cpu_wr_addr(addr), .cpu_wr_data(data), .cpu_wr_valid(b_valid), .cpu_wr_ready(b_ready),
    .OUTBUS_ADDR(b_addr), .OUTBUS_DATA(b_data), .OUTBUS_WE(b_we),
    .buf_count(b_count), .buf_idle(b_idle)
`ifdef OUTBUS_BUF_STATS_EN
    , .stat_writes(b_sw), .stat_peak(b_sp)
`endif
  );

  typedef struct {
    int         cyc;
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t exp_a[$];
  wr_t exp_b[$];
  wr_t obs_a[$];
  wr_t obs_b[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int saw_full = 0;
  int ready_bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitors: record every strobe seen half a cycle after the edge.
  always @(negedge clk) begin
    if (a_we === 1'b1) obs_a.push_back(wr_t'{cyc, a_addr, a_data});
    if (b_we === 1'b1) obs_b.push_back(wr_t'{cyc, b_addr, b_data});
  end

  // Backpressure monitor on the slow-draining instance.
  always @(negedge clk) begin
    if (b_count == 3'd4 && b_ready === 1'b0) saw_full = 1;
    if (b_ready !== (b_count < 3'd4)) ready_bad = ready_bad + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    tests++;
    assert (got === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
    end
  endtask

  // Presents one write on the selected instance and returns just after the accepting edge.
  task automatic push_wr(input logic s, input logic [7:0] a, input logic [7:0] d);
    logic ok;
    ok = 1'b0;
    @(negedge clk);
    sel = s; valid = 1'b1; addr = a; data = d;
    for (int i = 0; i < 200; i++) begin
      if ((s ? b_ready : a_ready) === 1'b1) begin
        @(posedge clk);
        ok = 1'b1;
        if (s) exp_b.push_back(wr_t'{0, a, d});
        else   exp_a.push_back(wr_t'{0, a, d});
        break;
      end
      @(negedge clk);
    end
    chk("push_accept", {31'b0, ok}, 32'd1);
  endtask

  task automatic release_valid();
    @(negedge clk);
    valid = 1'b0;
  endtask

  // Waits for the expected writes to appear, then compares order, contents and spacing.
  task automatic drain_check(input logic s, input int gap, input string tag);
    wr_t eq[$];
    wr_t oq[$];
    int  n;
    n = s ? exp_b.size() : exp_a.size();
    for (int i = 0; i < 400; i++) begin
      if ((s ? obs_b.size() : obs_a.size()) >= n) break;
      @(negedge clk);
    end
    repeat (8) @(negedge clk);
    if (s) begin
      eq = exp_b; oq = obs_b; exp_b.delete(); obs_b.delete();
    end else begin
      eq = exp_a; oq = obs_a; exp_a.delete(); obs_a.delete();
    end
    chk({tag, "_count"}, oq.size(), eq.size());
    for (int i = 0; i < eq.size() && i < oq.size(); i++) begin
      chk({tag, "_addr"}, {24'b0, oq[i].a}, {24'b0, eq[i].a});
      chk({tag, "_data"}, {24'b0, oq[i].d}, {24'b0, eq[i].d});
      if (gap > 0 && i > 0) chk({tag, "_spacing"}, oq[i].cyc - oq[i-1].cyc, gap);
    end
  endtask

  initial begin
    // Reset held with a request pending.
    reset_n = 1'b0; sel = 1'b0; valid = 1'b1; addr = 8'h77; data = 8'h88;
    repeat (3) @(negedge clk);
    chk("rst_we",    {31'b0, a_we},    32'd0);
    chk("rst_addr",  {24'b0, a_addr},  32'd0);
    chk("rst_data",  {24'b0, a_data},  32'd0);
    chk("rst_ready", {31'b0, a_ready}, 32'd1);
    chk("rst_idle",  {31'b0, a_idle},  32'd1);
    chk("rst_count", {29'b0, a_count}, 32'd0);
    chk("rst_no_write_during", obs_a.size(), 0);
    valid = 1'b0;
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_no_write_after", obs_a.size(), 0);

    // Single write into empty buffer: strobe one cycle after acceptance.
    push_wr(1'b0, 8'h05, 8'hA5);
    @(negedge clk);
    valid = 1'b0;
    chk("single_n_we",    {31'b0, a_we},    32'd0);
    chk("single_n_count", {29'b0, a_count}, 32'd1);
    chk("single_n_idle",  {31'b0, a_idle},  32'd0);
    @(negedge clk);
    chk("single_n1_we",   {31'b0, a_we},    32'd1);
    chk("single_n1_addr", {24'b0, a_addr},  32'h05);
    chk("single_n1_data", {24'b0, a_data},  32'hA5);
    @(negedge clk);
    chk("single_n2_we",   {31'b0, a_we},    32'd0);
    chk("single_n2_addr", {24'b0, a_addr},  32'h05);
    chk("single_n2_data", {24'b0, a_data},  32'hA5);
    chk("single_n2_idle", {31'b0, a_idle},  32'd1);
    drain_check(1'b0, 0, "single");

    // Back-to-back stream at GAP_CYCLES=0: one strobe every 2 cycles, in order.
    for (int i = 1; i <= 6; i++) push_wr(1'b0, 8'(i), 8'(8'h10 + i));
    release_valid();
    drain_check(1'b0, 2, "fill_a");
    chk("fill_a_idle", {31'b0, a_idle}, 32'd1);

    // GAP_CYCLES=3 instance fills up and back-pressures; strobes 5 cycles apart.
    for (int i = 1; i <= 6; i++) push_wr(1'b1, 8'(8'h20 + i), 8'(8'hC0 + i));
    release_valid();
    drain_check(1'b1, 5, "fill_b");
    chk("fill_b_full_seen", saw_full, 1);
    chk("ready_decode", ready_bad, 0);

`ifdef OUTBUS_BUF_STATS_EN
    chk("stat_writes_a", {16'b0, a_sw}, 32'd7);
    chk("stat_writes_b", {16'b0, b_sw}, 32'd6);
    chk("stat_peak_a",   {29'b0, a_sp}, 32'd3);
    chk("stat_peak_b",   {29'b0, b_sp}, 32'd4);
`endif

    // Mid-operation reset: after the 6th push, 3 entries queued and a strobe is high.
    for (int i = 1; i <= 6; i++) push_wr(1'b0, 8'(8'h30 + i), 8'(8'h50 + i));
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_we",    {31'b0, a_we},    32'd0);
    chk("midrst_count", {29'b0, a_count}, 32'd0);
    chk("midrst_ready", {31'b0, a_ready}, 32'd1);
    valid = 1'b0;
    // Only the two strobes completed before reset are expected.
    exp_a = exp_a[0:1];
    drain_check(1'b0, 2, "midrst");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("midrst_no_replay", obs_a.size(), 0);
    chk("midrst_idle",  {31'b0, a_idle},  32'd1);
    chk("midrst_count_after", {29'b0, a_count}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
